// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared widths, MMIO window base and register offsets for the data-side memory.
package data_memory_pkg;
  localparam int ADDR = 16;
  localparam int W_OPR = 32;
  localparam int DEPTH_LOG2 = 10;
  localparam logic [ADDR-1:0] MMIO_BASE = 16'hFF00;
  localparam logic [ADDR-1:0] MMIO_CYCLE = 16'd0;
  localparam logic [ADDR-1:0] MMIO_OUT = 16'd1;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM with registered, write-first read data.
module dmem_ram #(
  parameter int W_OPR = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [W_OPR-1:0]      wdata_i,
  output logic [W_OPR-1:0]      rdata_o
);
  logic [W_OPR-1:0] mem_q [2**DEPTH_LOG2];
  logic [W_OPR-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= we_i ? wdata_i : mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory.sv
// data_memory: load/store responder with RAM, a free-running CYCLE counter and a
// one-entry valid/ready output port whose backpressure is returned as a stall.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W = W_OPR,
  parameter int RAM_AW = DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR-1:0]   addr_i,
  input  logic              write_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);
  logic              is_ram, is_cycle, is_out, ram_we, out_acc;
  logic              out_valid_q, out_valid_d, ram_sel_q;
  logic [DATA_W-1:0] cycle_q, out_data_q, out_data_d, mmio_d, mmio_q, ram_rdata;
  always_comb begin
    is_ram      = addr_i < MMIO_BASE;
    is_cycle    = addr_i == MMIO_BASE + MMIO_CYCLE;
    is_out      = addr_i == MMIO_BASE + MMIO_OUT;
    stall_o     = write_i & is_out & out_valid_q & ~out_ready_i;
    ram_we      = write_i & is_ram & ~stall_o;
    out_acc     = write_i & is_out & ~stall_o;
    out_valid_d = out_acc | (out_valid_q & ~out_ready_i);
    out_data_d  = out_acc ? data_i : out_data_q;
    mmio_d      = is_cycle ? cycle_q : is_out ? DATA_W'(out_valid_q) : '0;
  end
  dmem_ram #(
    .W_OPR(DATA_W),
    .DEPTH_LOG2(RAM_AW)
  ) u_ram (
    .clk(clk),
    .we_i(ram_we),
    .addr_i(addr_i[RAM_AW-1:0]),
    .wdata_i(data_i),
    .rdata_o(ram_rdata)
  );
  // MMIO reads are captured at the sampling edge so they line up with the RAM's registered output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mmio_q      <= '0;
      ram_sel_q   <= 1'b0;
    end else begin
      cycle_q     <= cycle_q + DATA_W'(1);
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mmio_q      <= mmio_d;
      ram_sel_q   <= is_ram;
    end
  end
  assign data_o      = ram_sel_q ? ram_rdata : mmio_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed vector table plus randomized run against a queue/array reference model.
module tb_data_memory;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = '0;
  logic        write = 1'b0;
  logic [31:0] data = '0;
  logic        ready = 1'b0;
  logic [31:0] data_o, out_data_o;
  logic        stall_o, out_valid_o;
  logic [15:0] sm_addr = 16'hFF00;
  logic        sm_write = 1'b0;
  logic [7:0]  sm_data = '0;
  logic        sm_ready = 1'b1;
  logic [7:0]  sm_data_o, sm_out_data;
  logic        sm_stall, sm_out_valid;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory dut (
    .clk(clk), .reset(reset), .addr_i(addr), .write_i(write), .data_i(data),
    .data_o(data_o), .stall_o(stall_o), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o), .out_ready_i(ready)
  );

  // narrow instance so the CYCLE wrap is reachable in a few hundred cycles
  data_memory #(.DATA_W(8)) dut_sm (
    .clk(clk), .reset(reset), .addr_i(sm_addr), .write_i(sm_write), .data_i(sm_data),
    .data_o(sm_data_o), .stall_o(sm_stall), .out_data_o(sm_out_data),
    .out_valid_o(sm_out_valid), .out_ready_i(sm_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a; logic w; logic [31:0] d; logic r;
    logic st; logic [31:0] q; logic v; logic [31:0] od;
  } vec_t;

  vec_t tbl[18];
  logic [31:0] xfers[$];
  logic [31:0] exp_x[6] = '{32'hA, 32'hB, 32'h10, 32'h11, 32'h12, 32'h13};

  logic [31:0] mmem[1024];
  bit          known[1024];
  logic [31:0] oq[$];
  logic [31:0] cyc, m_od, rdv;
  bit          rdk, m_stall;
  int          idx, sel;

  initial begin
    tbl[0]  = '{16'h0005, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{16'h0005, 1'b0, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[2]  = '{16'h0007, 1'b1, 32'h1,        1'b0, 1'b0, 32'h1,        1'b0, 32'h0};
    tbl[3]  = '{16'h0407, 1'b1, 32'hCAFE0001, 1'b0, 1'b0, 32'hCAFE0001, 1'b0, 32'h0};
    tbl[4]  = '{16'h0007, 1'b0, 32'h0,        1'b0, 1'b0, 32'hCAFE0001, 1'b0, 32'h0};
    tbl[5]  = '{16'hFF05, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[6]  = '{16'hFF05, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[7]  = '{16'h0005, 1'b0, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[8]  = '{16'hFF01, 1'b1, 32'hA,        1'b0, 1'b0, 32'h0,        1'b1, 32'hA};
    tbl[9]  = '{16'hFF05, 1'b1, 32'h99,       1'b0, 1'b0, 32'h0,        1'b1, 32'hA};
    tbl[10] = '{16'hFF01, 1'b1, 32'hB,        1'b0, 1'b1, 32'h1,        1'b1, 32'hA};
    tbl[11] = '{16'hFF01, 1'b1, 32'hB,        1'b1, 1'b0, 32'h1,        1'b1, 32'hB};
    for (int i = 0; i < 4; i++)
      tbl[12+i] = '{16'hFF01, 1'b1, 32'h10 + i, 1'b1, 1'b0, 32'h1, 1'b1, 32'h10 + i};
    tbl[16] = '{16'hFF01, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1,        1'b0, 32'h13};
    tbl[17] = '{16'hFF01, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h13};

    repeat (2) @(negedge clk);
    chk("rst_data", data_o, 0);
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_odata", out_data_o, 0);
    chk("rst_stall", 32'(stall_o), 0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      addr = tbl[i].a; write = tbl[i].w; data = tbl[i].d; ready = tbl[i].r;
      #1;
      chk($sformatf("row%0d_stall", i), 32'(stall_o), 32'(tbl[i].st));
      if (out_valid_o && ready) xfers.push_back(out_data_o);
      @(negedge clk);
      chk($sformatf("row%0d_data", i), data_o, tbl[i].q);
      chk($sformatf("row%0d_valid", i), 32'(out_valid_o), 32'(tbl[i].v));
      chk($sformatf("row%0d_odata", i), out_data_o, tbl[i].od);
    end
    chk("xfer_count", xfers.size(), 6);
    foreach (exp_x[i]) chk($sformatf("xfer%0d", i), i < xfers.size() ? xfers[i] : 32'hX, exp_x[i]);

    // reset in the middle of a stalled handshake
    addr = 16'hFF01; write = 1'b1; data = 32'h77; ready = 1'b0;
    @(negedge clk);
    chk("pend_valid", 32'(out_valid_o), 1);
    chk("pend_odata", out_data_o, 32'h77);
    addr = 16'h0005; write = 1'b0;
    @(negedge clk);
    chk("pend_load", data_o, 32'hDEADBEEF);
    addr = 16'hFF01; write = 1'b1; data = 32'h88;
    #1 chk("pend_stall", 32'(stall_o), 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 0);
    chk("arst_data", data_o, 0);
    chk("arst_odata", out_data_o, 0);
    chk("arst_stall", 32'(stall_o), 0);

    // CYCLE counter: data_o after edge k (counted from 0 after release) reads k
    addr = 16'hFF00; write = 1'b0; ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 258; k++) begin
      @(negedge clk);
      if (k == 10) begin
        chk("cycle_10", data_o, 10);
        write = 1'b1; data = 32'h0;
      end
      if (k == 20) chk("cycle_20_wr_ignored", data_o, 20);
      if (k == 10 || k >= 255) chk($sformatf("cycle8_%0d", k), 32'(sm_data_o), k % 256);
    end

    // randomized run against the reference model
    @(negedge clk) reset = 1'b0;
    write = 1'b0;
    @(negedge clk) reset = 1'b1;
    foreach (known[i]) known[i] = 0;
    cyc = 0; m_od = 0; m_stall = 0; oq.delete();
    for (int n = 0; n < 3000; n++) begin
      if (!m_stall) begin
        sel = $urandom_range(0, 9);
        addr = sel < 6 ? 16'(($urandom_range(0, 3) << 10) | $urandom_range(0, 63)) :
               sel == 6 ? 16'hFF00 : sel < 9 ? 16'hFF01 : 16'hFF00 + 16'($urandom_range(2, 255));
        write = $urandom_range(0, 1) == 1;
        data = $urandom;
      end
      ready = $urandom_range(0, 2) != 0;
      #1;
      m_stall = write && addr == 16'hFF01 && oq.size() != 0 && !ready;
      chk("rnd_stall", 32'(stall_o), 32'(m_stall));
      rdk = 1;
      if (addr < 16'hFF00) begin
        idx = int'(addr[9:0]);
        if (write) begin mmem[idx] = data; known[idx] = 1; end
        rdv = mmem[idx]; rdk = known[idx];
      end else if (addr == 16'hFF00) rdv = cyc;
      else if (addr == 16'hFF01) rdv = 32'(oq.size() != 0);
      else rdv = 0;
      if (oq.size() != 0 && ready) void'(oq.pop_front());
      if (write && addr == 16'hFF01 && !m_stall) begin oq.push_back(data); m_od = data; end
      cyc++;
      @(negedge clk);
      if (rdk) chk("rnd_data", data_o, rdv);
      chk("rnd_valid", 32'(out_valid_o), 32'(oq.size() != 0));
      chk("rnd_odata", out_data_o, m_od);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_memory.md
# data_memory

Data-side memory responder for the load/store port of the execute stage. It accepts a word address and a write strobe every cycle, performs stores at the clock edge, and returns load data one cycle later, when the execute stage's registered load flag selects it. It also decodes a small MMIO window containing a free-running cycle counter and a one-entry output port with a valid/ready handshake. Backpressure from that port is returned to the pipeline as a stall.

## Interface

- ADDR, 16, word-address width, matching the execute stage's load/store address.
- W_OPR, 32, data word width.
- DEPTH_LOG2, 10, log2 of RAM words.
- MMIO_BASE, 16'hFF00, first MMIO word address; addresses >= MMIO_BASE are MMIO.

Ports:

- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- addr_i  input  ADDR  word address, sampled every cycle.
- write_i  input  1  store strobe; already qualified by valid in the execute stage.
- data_i  input  W_OPR  store data.
- data_o  output  W_OPR  load data for the address presented in the previous cycle.
- stall_o  output  1  pipeline stall request, combinational.
- out_data_o  output  W_OPR  output-port data.
- out_valid_o  output  1  output-port data valid.
- out_ready_i  input  1  consumer accepts out_data_o this cycle.

## Operation

- The RAM region is addr_i < MMIO_BASE. The index is addr_i[DEPTH_LOG2-1:0]; higher bits alias.
- Stores: when write_i=1 and stall_o=0, RAM[index] <= data_i at the posedge.
- Loads: data_o is registered. It holds the word at the address sampled at the previous posedge.
- Same-address write and read in one cycle is write-first: data_o shows the new data next cycle.
- MMIO_BASE+0 is CYCLE. It is a read-only W_OPR counter that increments every cycle and wraps from all-ones to 0. Writes to it are ignored. A read returns the value the counter had at the sampling edge.
- MMIO_BASE+1 is OUT.
  - A write loads out_data_o and sets out_valid_o.
  - A read returns {W_OPR-1 zeros, out_valid_o}.
- Handshake: a transfer occurs at a posedge with out_valid_o=1 and out_ready_i=1. On a transfer, out_valid_o clears unless a new OUT write is accepted in the same cycle. In that case out_data_o takes the new data and out_valid_o stays 1.
- stall_o = write_i & (addr_i==MMIO_BASE+1) & out_valid_o & ~out_ready_i. While stall_o=1:
  - no state except CYCLE and data_o changes;
  - the pipeline holds addr_i, write_i and data_i stable until stall_o falls.
- Other MMIO addresses read 0; writes to them are ignored and never stall.
- Loads never stall.

## Timing

- Reset (asynchronous, reset=0) drives:
  - data_o=0;
  - out_data_o=0;
  - out_valid_o=0;
  - CYCLE=0;
  - stall_o=0, which follows from out_valid_o=0.
- RAM contents are not reset.
- Load latency is exactly 1 cycle: address at edge N, data on data_o after edge N, consumed at edge N+1.
- Store latency is 0: a store is visible to a load addressed in the next cycle.
- OUT write to out_valid_o: 1 cycle.
- out_ready_i to stall_o release: combinational, same cycle.
- Reset asserted mid-handshake drops out_valid_o immediately; the pending word is lost.
- Back-to-back OUT writes with out_ready_i held at 1 sustain one word per cycle with no stall.

## Structure

- Shared package or include, alongside the existing params include, holds:
  - ADDR and W_OPR;
  - MMIO_BASE;
  - the offsets MMIO_CYCLE=0 and MMIO_OUT=1.
- One sub-module, dmem_ram: a single-port synchronous RAM with write-first read, parameterised by W_OPR and DEPTH_LOG2.
- Address decode, the counter, the output-port register and the data_o mux live in data_memory.
- Target size is about 150–250 lines total.

## Test plan

- Basic store and load: store 32'hDEADBEEF at 0x0005, then load 0x0005 in the next cycle. data_o must read 32'hDEADBEEF one cycle after the load address.
- Same-cycle hazard and aliasing:
  - write and read 0x0007 in the same cycle with data 32'h1 → data_o=32'h1 next cycle;
  - store to 0x0407 (DEPTH_LOG2=10), then load 0x0007 → returns the stored value.
- CYCLE counter: release reset, then read CYCLE at edge 10 → data_o=10 after that edge. Force the counter to all-ones → reads 0 the next cycle.
- OUT backpressure:
  1. hold out_ready_i=0 and write 32'hA to OUT → out_valid_o=1 and out_data_o=32'hA;
  2. write 32'hB → stall_o=1, and out_data_o stays 32'hA;
  3. raise out_ready_i → stall_o=0 in the same cycle, and out_data_o=32'hB with out_valid_o=1 next cycle.
- Streaming and reset:
  - with out_ready_i=1, 4 consecutive OUT writes produce 4 transfers and stall_o is never 1;
  - assert reset while out_valid_o=1 → out_valid_o=0 and data_o=0 immediately.
- Unmapped MMIO: store to MMIO_BASE+5, then load it → data_o=0, stall_o=0, and RAM is unchanged.
